nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit ripple slice.
- Latches full-width operands on a start handshake.
- Feeds one nibble per cycle (LSB first) into the 4-bit slice and registers the slice carry between nibbles.
- Assembles the result and presents it, with a one-cycle done pulse, to the display/register stage downstream.
- Trades latency for area: one 4-bit slice serves any WIDTH.

---
 rtl/nibble_serial_adder_pkg.sv | 5 +
 rtl/nibble_serial_adder_if.sv | 7 +
 rtl/nibble_serial_adder_full_adder.sv | 19 +
 rtl/nibble_serial_adder.sv | 69 ++++++
 tb/tb_nibble_serial_adder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// nibble_adder_pkg: shared state type and slice width for the nibble-serial adder
package nibble_adder_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_adder_if #(parameter int WIDTH = 16);
  logic start, sub, cin, ready, busy, done, cout;
  logic [WIDTH-1:0] A, B, S;
  modport master(output start, sub, A, B, cin, input ready, busy, done, S, cout);
  modport slave(input start, sub, A, B, cin, output ready, busy, done, S, cout);
endinterface

// File: rtl/nibble_serial_adder_full_adder.sv
// full_adder: 4-bit ripple-carry slice
module full_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout
);
  logic [4:0] c;
  always_comb begin
    c[0] = cin;
    S = '0;
    for (int i = 0; i < 4; i++) begin
      S[i] = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end
  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add/subtract, one nibble per cycle through a single 4-bit slice
module nibble_serial_adder import nibble_adder_pkg::*; #(
  parameter int WIDTH = 16
) (
  input logic Clk,
  input logic Reset,
  nibble_serial_adder_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state;
  logic [WIDTH-1:0] a_r, b_r, sum, sum_next;
  logic [IW-1:0] idx;
  logic carry, nc;
  logic [NIBBLE_W-1:0] na, nb, ns;
  assign na = a_r[idx*NIBBLE_W +: NIBBLE_W];
  assign nb = b_r[idx*NIBBLE_W +: NIBBLE_W];
  full_adder u_slice (.A(na), .B(nb), .cin(carry), .S(ns), .cout(nc));
  always_comb begin
    sum_next = sum;
    sum_next[idx*NIBBLE_W +: NIBBLE_W] = ns;
  end
  // subtraction is A + ~B + 1, so inversion and the forced carry happen at accept time
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      sum <= '0;
      carry <= 1'b0;
      idx <= '0;
      bus.ready <= 1'b1;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_r <= bus.A;
          b_r <= bus.sub ? ~bus.B : bus.B;
          carry <= bus.sub | bus.cin;
          idx <= '0;
          bus.ready <= 1'b0;
          bus.busy <= 1'b1;
          state <= ADD;
        end
        ADD: begin
          sum <= sum_next;
          carry <= nc;
          idx <= idx + 1'b1;
          if (idx == IW'(NIBBLES - 1)) begin
            bus.S <= sum_next;
            bus.cout <= nc;
            bus.done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          bus.ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: randomized and directed checks against an arithmetic reference model
module tb_nibble_serial_adder;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;
  nibble_serial_adder_if #(16) bus ();
  nibble_serial_adder #(.WIDTH(16)) dut (.Clk(Clk), .Reset(Reset), .bus(bus.slave));
  int passed = 0;
  int total = 0;
  function automatic logic [16:0] model(input logic [15:0] a, b, input logic c, s);
    if (s) return {a >= b, 16'(a - b)};
    return 17'(a) + 17'(b) + 17'(c);
  endfunction
  task automatic do_op(input logic [15:0] a, b, input logic c, s, input bit hold,
                       output int lat, output int rlow, output logic dn_after, output logic rdy_after);
    bus.A = a;
    bus.B = b;
    bus.cin = c;
    bus.sub = s;
    bus.start = 1'b1;
    @(negedge Clk);
    lat = 0;
    rlow = 0;
    if (!hold) bus.start = 1'b0;
    while (!bus.done && lat < 20) begin
      if (!bus.ready) rlow++;
      if (hold) begin
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
        bus.sub = 1'($urandom);
        bus.cin = 1'($urandom);
      end
      @(negedge Clk);
      lat++;
    end
    if (!bus.ready) rlow++;
    @(negedge Clk);
    dn_after = bus.done;
    rdy_after = bus.ready;
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if ({bus.ready, bus.busy, bus.done, bus.cout} !== 4'b1000 || bus.S !== 16'h0)
      $display("FAIL reset_state: rdy/busy/done/cout=%b S=%h want 1000 S=0000", {bus.ready, bus.busy, bus.done, bus.cout}, bus.S);
    else passed++;
  endtask
  task automatic test_basic;
    int lat, rlow;
    logic dn, rdy;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, lat, rlow, dn, rdy);
    total++;
    if ({bus.cout, bus.S} !== 17'h05555) $display("FAIL basic_sum: got %h want 05555", {bus.cout, bus.S});
    else passed++;
    total++;
    if (lat !== 4) $display("FAIL basic_latency: got %0d want 4", lat);
    else passed++;
    total++;
    if (rlow !== 5) $display("FAIL basic_ready_low: got %0d want 5", rlow);
    else passed++;
    total++;
    if (dn !== 1'b0 || rdy !== 1'b1) $display("FAIL basic_done_pulse: done=%b ready=%b want 0 1", dn, rdy);
    else passed++;
    // async reset clears outputs between edges
    #2 Reset = 1'b1;
    #1;
    total++;
    if (bus.S !== 16'h0 || bus.ready !== 1'b1) $display("FAIL async_reset: S=%h ready=%b want 0000 1", bus.S, bus.ready);
    else passed++;
    @(negedge Clk);
    Reset = 1'b0;
  endtask
  task automatic test_ripple;
    logic [15:0] av [4] = '{16'hFFFF, 16'hFFFF, 16'h0005, 16'h0007};
    logic [15:0] bv [4] = '{16'h0001, 16'h0000, 16'h0007, 16'h0005};
    logic cv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic sv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [16:0] want [4] = '{17'h10000, 17'h10000, 17'h0FFFE, 17'h10002};
    int lat, rlow;
    logic dn, rdy;
    for (int i = 0; i < 4; i++) begin
      do_op(av[i], bv[i], cv[i], sv[i], 1'b0, lat, rlow, dn, rdy);
      total++;
      if ({bus.cout, bus.S} !== want[i]) $display("FAIL edge_case_%0d: got %h want %h", i, {bus.cout, bus.S}, want[i]);
      else passed++;
    end
  endtask
  task automatic test_random;
    int lat, rlow;
    logic dn, rdy;
    logic [15:0] a, b;
    logic c, s;
    int bad = 0;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      s = 1'($urandom);
      do_op(a, b, c, s, 1'b0, lat, rlow, dn, rdy);
      total++;
      if ({bus.cout, bus.S} !== model(a, b, c, s) || lat !== 4) begin
        $display("FAIL random_%0d: a=%h b=%h cin=%b sub=%b got %h lat %0d want %h lat 4", i, a, b, c, s, {bus.cout, bus.S}, lat, model(a, b, c, s));
        bad++;
      end else passed++;
    end
  endtask
  task automatic test_back_to_back;
    int lat, rlow;
    logic dn, rdy;
    do_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b1, lat, rlow, dn, rdy);
    total++;
    if ({bus.cout, bus.S} !== 17'h0BCDF) $display("FAIL hold_start: got %h want 0BCDF", {bus.cout, bus.S});
    else passed++;
    do_op(16'h8000, 16'h8001, 1'b0, 1'b1, 1'b0, lat, rlow, dn, rdy);
    total++;
    if ({bus.cout, bus.S} !== 17'h0FFFF || lat !== 4) $display("FAIL back_to_back: got %h lat %0d want 0FFFF lat 4", {bus.cout, bus.S}, lat);
    else passed++;
  endtask
  task automatic test_abort;
    int lat, rlow;
    int pulses = 0;
    logic dn, rdy;
    bus.A = 16'h0F0F;
    bus.B = 16'h0101;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge Clk);
    bus.start = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({bus.ready, bus.busy, bus.done} !== 3'b100 || bus.S !== 16'h0)
      $display("FAIL abort_state: rdy/busy/done=%b S=%h want 100 S=0000", {bus.ready, bus.busy, bus.done}, bus.S);
    else passed++;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (bus.done) pulses++;
    end
    total++;
    if (pulses !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    else passed++;
    do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, lat, rlow, dn, rdy);
    total++;
    if ({bus.cout, bus.S} !== 17'h01010) $display("FAIL abort_recover: got %h want 01010", {bus.cout, bus.S});
    else passed++;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_ripple;
    test_random;
    test_back_to_back;
    test_abort;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
